// File: rtl/conway_life_cell.sv
// conway_life_cell
//
// One cell of a synchronous Game of Life array. The cell holds a single state
// bit and advances it one generation per rising clock edge when enabled. The
// bit can also be loaded directly through a write port, or through a serial
// scan path that shifts patterns into or out of the array.
//
// Ports
//   clk                 system clock, all state changes on the rising edge
//   reset               asynchronous reset, active-low, clears alive
//   n ne e se s sw w nw current state of the eight neighbouring cells
//   write / val         direct-load strobe and the value it loads
//   enb                 generation-step enable
//   scan / scan_val     scan-mode select and the serial value it loads
//   alive               registered cell state (flop output, no input path)
//
// Next-state priority: reset, scan, write, enb (Conway rule), hold.

module conway_life_cell (
  input  logic clk,
  input  logic reset,
  input  logic n,
  input  logic ne,
  input  logic e,
  input  logic se,
  input  logic s,
  input  logic sw,
  input  logic w,
  input  logic nw,
  input  logic write,
  input  logic val,
  input  logic enb,
  input  logic scan,
  input  logic scan_val,
  output logic alive
);

  // Population count of the neighbourhood, 0..8.
  function automatic logic [3:0] count_neighbours(input logic [7:0] nb);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, nb[i]};
    end
    return sum;
  endfunction

  // Conway rule: three neighbours gives birth, two keeps the current state,
  // anything else is death by isolation or overcrowding.
  function automatic logic life_rule(input logic [3:0] cnt, input logic cur);
    logic nxt;
    case (cnt)
      4'd2:    nxt = cur;
      4'd3:    nxt = 1'b1;
      default: nxt = 1'b0;
    endcase
    return nxt;
  endfunction

  logic [7:0] nbrs;
  logic [3:0] nbr_cnt;
  logic       alive_nxt;

  assign nbrs    = {nw, w, sw, s, se, e, ne, n};
  assign nbr_cnt = count_neighbours(nbrs);

  always_comb begin
    alive_nxt = alive;
    if (scan) begin
      alive_nxt = scan_val;
    end else if (write) begin
      alive_nxt = val;
    end else if (enb) begin
      alive_nxt = life_rule(nbr_cnt, alive);
    end
  end

  // State register: the only stage; alive is the flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive <= 1'b0;
    end else begin
      alive <= alive_nxt;
    end
  end

endmodule

// File: tb/tb_conway_life_cell.sv
module tb_conway_life_cell;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic n = 0, ne = 0, e = 0, se = 0, s = 0, sw = 0, w = 0, nw = 0;
  logic write = 0, val = 0, enb = 0, scan = 0, scan_val = 0;
  logic alive;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;
  logic exp_alive = 1'b0;

  conway_life_cell dut (
    .clk(clk), .reset(reset),
    .n(n), .ne(ne), .e(e), .se(se), .s(s), .sw(sw), .w(w), .nw(nw),
    .write(write), .val(val), .enb(enb), .scan(scan), .scan_val(scan_val),
    .alive(alive)
  );

  always #5 clk = ~clk;

  // Behavioural model: the Game of Life rule in plain integer arithmetic.
  always @(posedge clk or negedge reset) begin
    int cnt;
    if (!reset) begin
      exp_alive = 1'b0;
    end else begin
      cnt = int'(n) + int'(ne) + int'(e) + int'(se) + int'(s) + int'(sw) + int'(w) + int'(nw);
      if (scan)       exp_alive = scan_val;
      else if (write) exp_alive = val;
      else if (enb) begin
        if (cnt == 3)      exp_alive = 1'b1;
        else if (cnt != 2) exp_alive = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (alive !== exp_alive) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t alive=%b expected=%b", $time, alive, exp_alive);
      end
    end
  end

  task automatic check(input string name, input logic exp);
    n_cmp++;
    if (alive !== exp) begin
      n_bad++;
      $display("FAIL %s alive=%b expected=%b", name, alive, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nbrs(input logic [7:0] v);
    {nw, w, sw, s, se, e, ne, n} = v;
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0);
    reset = 1'b1;
    cmp_en = 1'b1;
    enb = 1'b1;
    cyc(); check("idle_zero_nbrs", 1'b0);

    // Birth, survival, death
    n = 1; e = 1; s = 1;
    cyc(); check("birth_cnt3", 1'b1);
    s = 0;
    cyc(); check("survive_cnt2", 1'b1);
    n = 0;
    cyc(); check("death_cnt1", 1'b0);
    n = 1; e = 1; s = 1;
    cyc(); check("rebirth_cnt3", 1'b1);
    w = 1;
    cyc(); check("death_cnt4", 1'b0);

    // Write and disable
    set_nbrs(8'h00);
    enb = 0; write = 1; val = 1;
    cyc(); check("write_one", 1'b1);
    write = 0; val = 0; e = 1; s = 1;
    cyc(); check("hold_enb0", 1'b1);
    enb = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(); check("survive_5cyc", 1'b1);
    end
    s = 0;
    cyc(); check("death_after_drop_s", 1'b0);

    // Scan override (count 1: e only)
    scan_val = 1; scan = 1;
    cyc(); check("scan_load_one", 1'b1);
    scan_val = 0;
    cyc(); check("scan_load_zero", 1'b0);
    scan = 0; scan_val = 1;
    cyc(); check("scan_drop_ignored", 1'b0);

    // Priority: scan beats write
    scan_val = 0; write = 1; val = 1;
    cyc(); check("write_before_prio", 1'b1);
    scan = 1; scan_val = 0; write = 1; val = 1;
    cyc(); check("scan_beats_write", 1'b0);
    scan = 0; write = 0; val = 0;

    // Asynchronous reset between edges
    write = 1; val = 1;
    cyc(); check("write_before_areset", 1'b1);
    write = 0; val = 0; enb = 0;
    #2 reset = 1'b0;
    #1 check("async_reset_no_clk", 1'b0);
    #1 reset = 1'b1;
    cyc(); check("after_areset_hold", 1'b0);

    // Randomized stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      set_nbrs(8'($urandom));
      enb      = ($urandom_range(0, 3) != 0);
      write    = ($urandom_range(0, 7) == 0);
      val      = 1'($urandom);
      scan     = ($urandom_range(0, 9) == 0);
      scan_val = 1'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b0;
        #1 check("rand_async_reset", 1'b0);
        #1 reset = 1'b1;
      end
      cyc();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
